keypad_scanner: RTL

//  Input-side counterpart to the multiplexed 7-seg display driver: scans a 4x4 hex keypad
//  by driving one column low at a time and sampling the rows. Synchronizes and debounces
//  the rows and emits one 4-bit hex key code per press over a valid/ready handshake.
//  Its output feeds the MIPS memory-mapped I/O input register.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_scanner_input_sync.sv | 39 +++
 rtl/keypad_scanner.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and constants for the 4x4 hex keypad scanner.
//            - kp_state_t : scan/debounce FSM state encoding
//            - KEY_MAP    : hex code per {row,col} position
//            - lowest_low : priority encoder picking the lowest active-low row
// Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   // Index is {row[1:0], col[1:0]}; layout of a standard hex keypad
   // (row 3 carries E/0/F/D in place of the */0/#/D legends).
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   // Lowest-index low bit wins when several rows are pulled low together.
   function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (!r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_input_sync.sv
`default_nettype none
// ============================================================================
// Module   : input_sync
// Purpose  : N-bit two-flop synchronizer for asynchronous inputs. Resets to
//            all-ones, i.e. the released level of the pulled-up keypad rows.
// Ports    : clock   in  1      system clock
//            reset_n in  1      asynchronous active-low reset
//            d       in  WIDTH  asynchronous input
//            q       out WIDTH  synchronized output
// Revision : 1.0  initial release
// ============================================================================
module input_sync
   import keypad_pkg::*;
#(
   parameter int WIDTH = NUM_ROWS
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 hex keypad one column at a time, debounces presses
//            and releases on the scan tick, and delivers one hex code per
//            press over a valid/ready handshake.
// Ports    : clock     in  1  system clock (100MHz)
//            reset_n   in  1  asynchronous active-low reset
//            rows      in  4  keypad rows, active-low, asynchronous
//            cols      out 4  column drive, active-low, one bit low
//            key_code  out 4  accepted key code, stable while key_valid
//            key_valid out 1  key_code holds an unconsumed key
//            key_ready in  1  consumer takes key_code on valid && ready
//            key_held  out 1  accepted key still physically pressed
//            overrun   out 1  1-cycle pulse: accept dropped, key pending
// Config   : KEYPAD_REPEAT_EN - when defined, a held key is re-accepted
//            every REPEAT_TICKS scan ticks.
// Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 20000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int REPEAT_TICKS = 2500
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overrun
);

   localparam int C_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int C_CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(SCAN_DIV - 1);
   localparam logic [C_CNT_W-1:0] C_DEB_MAX = C_CNT_W'(DEBOUNCE_CNT);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

   // ---------------------------------------------------------------------
   // Row synchronizer and decode
   // ---------------------------------------------------------------------
   logic [3:0] w_rows_s;
   logic       w_hit;
   logic [1:0] w_row_idx;

   input_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (rows),
      .q       (w_rows_s)
   );

   assign w_hit     = ~&w_rows_s;
   assign w_row_idx = lowest_low(w_rows_s);

   // ---------------------------------------------------------------------
   // Column dwell prescaler
   // ---------------------------------------------------------------------
   logic [C_PRE_W-1:0] r_prescaler;
   logic               w_tick;

   assign w_tick = (r_prescaler == C_PRE_MAX);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prescaler <= '0;
      end else if (w_tick) begin
         r_prescaler <= '0;
      end else begin
         r_prescaler <= r_prescaler + C_PRE_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Scan / debounce FSM
   // ---------------------------------------------------------------------
   kp_state_t          r_state, w_state_next;
   logic [C_CNT_W-1:0] r_cnt, w_cnt_next;
   logic [1:0]         r_col_idx, w_col_next;
   logic [1:0]         r_row_idx, w_row_next;
   logic               w_accept_deb;
   logic               w_repeat;
   logic               w_accept;
   logic [3:0]         r_key_code;
   logic               r_key_valid;
   logic               r_key_held;
   logic               r_overrun;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= SCAN;
         r_cnt     <= '0;
         r_col_idx <= 2'd0;
         r_row_idx <= 2'd0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_col_idx <= w_col_next;
         r_row_idx <= w_row_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_col_next   = r_col_idx;
      w_row_next   = r_row_idx;
      w_accept_deb = 1'b0;
      if (w_tick) begin
         unique case (r_state)
            SCAN: begin
               if (w_hit) begin
                  w_row_next   = w_row_idx;
                  w_cnt_next   = C_CNT_ONE;
                  w_state_next = DEBOUNCE;
               end else begin
                  w_col_next = r_col_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               // Only the same row on the same column counts as agreement.
               if (w_hit && (w_row_idx == r_row_idx)) begin
                  if (r_cnt >= C_DEB_MAX - C_CNT_ONE) begin
                     w_state_next = PRESSED;
                     w_accept_deb = 1'b1;
                  end else begin
                     w_cnt_next = r_cnt + C_CNT_ONE;
                  end
               end else begin
                  w_state_next = SCAN;
                  w_col_next   = r_col_idx + 2'd1;
               end
            end
            PRESSED: begin
               if (!w_hit) begin
                  w_cnt_next   = C_CNT_ONE;
                  w_state_next = RELEASE;
               end
            end
            RELEASE: begin
               if (w_hit) begin
                  // Bounce during release: back to held, no second accept.
                  w_state_next = PRESSED;
               end else if (r_cnt >= C_DEB_MAX - C_CNT_ONE) begin
                  w_state_next = SCAN;
                  w_col_next   = r_col_idx + 2'd1;
               end else begin
                  w_cnt_next = r_cnt + C_CNT_ONE;
               end
            end
            default: w_state_next = SCAN;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Optional auto-repeat while held
   // ---------------------------------------------------------------------
`ifdef KEYPAD_REPEAT_EN
   localparam int C_REP_W = $clog2(REPEAT_TICKS + 1);
   localparam logic [C_REP_W-1:0] C_REP_MAX = C_REP_W'(REPEAT_TICKS);

   logic [C_REP_W-1:0] r_rep_cnt;

   assign w_repeat = w_tick && (r_state == PRESSED) && (w_state_next == PRESSED)
                     && (r_rep_cnt == C_REP_MAX - C_REP_W'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rep_cnt <= '0;
      end else if ((r_state != PRESSED) || (w_state_next != PRESSED)) begin
         r_rep_cnt <= '0;
      end else if (w_tick) begin
         r_rep_cnt <= w_repeat ? '0 : r_rep_cnt + C_REP_W'(1);
      end
   end
`else
   assign w_repeat = 1'b0;
`endif

   assign w_accept = w_accept_deb | w_repeat;

   // ---------------------------------------------------------------------
   // Output handshake. A consume on the same cycle as an accept frees the
   // slot, so the new key is taken rather than flagged as an overrun.
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun  <= 1'b0;
         r_key_held <= (w_state_next == PRESSED) || (w_state_next == RELEASE);
         if (w_accept) begin
            if (!r_key_valid || key_ready) begin
               r_key_code  <= KEY_MAP[{r_row_idx, r_col_idx}];
               r_key_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_key_valid && key_ready) begin
            r_key_valid <= 1'b0;
         end
      end
   end

   assign cols      = ~(4'b0001 << r_col_idx);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;
   assign overrun   = r_overrun;

endmodule
`default_nettype wire
